// File: rtl/seq_divider32_pkg.sv
// ============================================================================
// seq_divider32_pkg : shared divider/multiplier types, constants and helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_TAG_W = 4;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Stand-alone incrementer used for sign correction of results and operands.
    function automatic logic [DIV_WIDTH-1:0] twos_negate(input logic [DIV_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider32_addsub33.sv
// ============================================================================
// div_addsub33 : 33-bit add/subtract on a Kogge-Stone parallel-prefix carry net
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    localparam int LEVELS = $clog2(W);

    logic [W-1:0] w_b_eff;
    logic [W-1:0] w_p0;
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;

    // Carry-in is folded into bit 0's generate, so w_g[i] ends as carry-out of bit i.
    always_comb begin
        w_b_eff = b ^ {W{sub}};
        w_p0    = a ^ w_b_eff;
        w_g     = (a & w_b_eff) | {{(W-1){1'b0}}, w_p0[0] & sub};
        w_p     = w_p0;
        for (int l = 0; l < LEVELS; l++) begin
            w_g = w_g | (w_p & (w_g << (1 << l)));
            w_p = w_p & ((w_p << (1 << l)) | ((W'(1) << (1 << l)) - W'(1)));
        end
        sum = w_p0 ^ {w_g[W-2:0], sub};
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider32.sv
// ============================================================================
// seq_divider32 : sequential radix-2 non-restoring 32-bit signed/unsigned divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider32 import seq_divider32_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t             r_state;
    div_state_t             w_state_next;
    logic [DIV_CNT_W-1:0]   r_count;
    logic [WIDTH:0]         r_rem;
    logic [WIDTH-1:0]       r_quo;
    logic [WIDTH-1:0]       r_dvs_mag;
    logic [WIDTH-1:0]       r_dvd_orig;
    logic                   r_q_neg;
    logic                   r_r_neg;
    logic [TAG_W-1:0]       r_tag;

    logic                   w_accept;
    logic                   w_dvd_neg;
    logic                   w_dvs_neg;
    logic [WIDTH-1:0]       w_dvd_mag;
    logic [WIDTH-1:0]       w_dvs_mag;
    logic [WIDTH:0]         w_add_a;
    logic [WIDTH:0]         w_add_sum;
    logic                   w_add_sub;
    logic [WIDTH:0]         w_rem_fixed;
    logic [WIDTH-1:0]       w_quo_res;
    logic [WIDTH-1:0]       w_rem_res;
    logic                   w_dbz;

    assign w_accept  = in_valid && (r_state == IDLE) && !flush;
    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? twos_negate(dividend) : dividend;
    assign w_dvs_mag = w_dvs_neg ? twos_negate(divisor)  : divisor;

    // One adder serves both the iteration step and the FIX restore (add only).
    assign w_add_a   = (r_state == FIX) ? r_rem : {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_add_sub = (r_state == ITER) & ~r_rem[WIDTH];

    div_addsub33 #(
        .W   (WIDTH + 1)
    ) u_addsub (
        .a   (w_add_a),
        .b   ({1'b0, r_dvs_mag}),
        .sub (w_add_sub),
        .sum (w_add_sum)
    );

    assign w_rem_fixed = r_rem[WIDTH] ? w_add_sum : r_rem;
    assign w_quo_res   = r_q_neg ? twos_negate(r_quo) : r_quo;
    assign w_rem_res   = r_r_neg ? twos_negate(w_rem_fixed[WIDTH-1:0]) : w_rem_fixed[WIDTH-1:0];
    assign w_dbz       = (r_dvs_mag == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ITER;
            end
            ITER: begin
                if (r_count == '0) w_state_next = FIX;
            end
            FIX: begin
                w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs_mag   <= '0;
            r_dvd_orig  <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_tag       <= '0;
            out_tag     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_count    <= DIV_CNT_W'(DIV_ITERS - 1);
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_dvs_mag  <= w_dvs_mag;
            r_dvd_orig <= dividend;
            r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg    <= w_dvd_neg;
            r_tag      <= in_tag;
        end else if (r_state == ITER) begin
            r_rem   <= w_add_sum;
            r_quo   <= {r_quo[WIDTH-2:0], ~w_add_sum[WIDTH]};
            r_count <= r_count - 1'b1;
        end else if (r_state == FIX && !flush) begin
            out_tag <= r_tag;
            if (w_dbz) begin
                quotient    <= '1;
                remainder   <= r_dvd_orig;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= w_quo_res;
                remainder   <= w_rem_res;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider32.sv
// ============================================================================
// tb_seq_divider32 : self-checking bench for seq_divider32
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider32 dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tag     (out_tag),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference: plain integer division with truncation toward zero.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, tq, tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            tq = sa / sb;
            tr = sa % sb;
            q = tq[31:0]; r = tr[31:0]; dz = 1'b0;
        end
    endfunction

    task automatic start_op(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn);
        int n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_tag = tag; dividend = a; divisor = b; is_signed = sgn;
        @(negedge clk);
        in_valid = 1'b0;
        in_tag = 4'($urandom); dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic handoff;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat;
        start_op(4'hA, 32'd100, 32'd7, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL unsigned_latency: got %0d want 33", lat); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL unsigned_q: got %h want %h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL unsigned_r: got %h want %h", remainder, 32'd2); end
        checks++; if (out_tag !== 4'hA) begin errors++; $display("FAIL unsigned_tag: got %h want a", out_tag); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL unsigned_dbz: got %b want 0", div_by_zero); end
        handoff();
    endtask

    task automatic test_signed;
        int lat;
        start_op(4'h3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result(lat);
        checks++; if (quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed_q: got %h want fffffffd", quotient); end
        checks++; if (remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_r: got %h want ffffffff", remainder); end
        checks++; if (out_tag !== 4'h3) begin errors++; $display("FAIL signed_tag: got %h want 3", out_tag); end
        handoff();
    endtask

    task automatic test_overflow;
        int lat;
        start_op(4'h5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result(lat);
        checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q: got %h want 80000000", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL ovf_r: got %h want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
        handoff();
    endtask

    task automatic test_div_by_zero;
        int lat;
        start_op(4'h6, 32'h1234_5678, 32'h0, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL dbz_latency: got %0d want 33", lat); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_q: got %h want ffffffff", quotient); end
        checks++; if (remainder !== 32'h1234_5678) begin errors++; $display("FAIL dbz_r: got %h want 12345678", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        handoff();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] eq, er;
        logic ez;
        model(32'd1000, 32'd33, 1'b0, eq, er, ez);
        start_op(4'h9, 32'd1000, 32'd33, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (quotient !== eq || remainder !== er || out_tag !== 4'h9)
                begin errors++; $display("FAIL bp_hold[%0d]: got %h/%h/%h want %h/%h/9", i, quotient, remainder, out_tag, eq, er); end
        end
        // Issue request during the handoff cycle must not be taken.
        out_ready = 1'b1; in_valid = 1'b1; dividend = 32'd5; divisor = 32'd1; is_signed = 1'b0; in_tag = 4'h1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_handoff: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got %b want 1", in_ready); end
    endtask

    task automatic test_flush;
        int lat;
        int seen = 0;
        start_op(4'hC, 32'hDEAD_BEEF, 32'h1234, 1'b0);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
        start_op(4'hD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_next_q: got %h want ffffffff", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL flush_next_r: got %h want 0", remainder); end
        handoff();
    endtask

    task automatic test_async_reset;
        int lat;
        start_op(4'h7, 32'd50, 32'd7, 1'b1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL async_reset_state: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        checks++; if (quotient !== 32'h0 || out_tag !== 4'h0)
            begin errors++; $display("FAIL async_reset_outputs: got q=%h tag=%h want 0/0", quotient, out_tag); end
        #1 reset = 1'b0;
        @(negedge clk);
        start_op(4'h2, 32'd10, 32'd3, 1'b0);
        wait_result(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
        checks++; if (quotient !== 32'd3 || remainder !== 32'd1)
            begin errors++; $display("FAIL post_reset_result: got %h/%h want 3/1", quotient, remainder); end
        handoff();
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a, b, eq, er;
        logic sgn, ez;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = a;
                default: b = $urandom;
            endcase
            sgn = 1'($urandom);
            model(a, b, sgn, eq, er, ez);
            start_op(4'(i), a, b, sgn);
            wait_result(lat);
            checks++; if (lat !== 33) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 33", i, lat); end
            checks++; if (quotient !== eq) begin errors++; $display("FAIL rand_q[%0d] %h/%h s=%b: got %h want %h", i, a, b, sgn, quotient, eq); end
            checks++; if (remainder !== er) begin errors++; $display("FAIL rand_r[%0d] %h/%h s=%b: got %h want %h", i, a, b, sgn, remainder, er); end
            checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL rand_dbz[%0d]: got %b want %b", i, div_by_zero, ez); end
            checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL rand_tag[%0d]: got %h want %h", i, out_tag, 4'(i)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handoff();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_tag = 4'h0; dividend = 32'h0; divisor = 32'h0; is_signed = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_by_zero();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_divider32.md
# seq_divider32

Sequential radix-2 non-restoring integer divider for the integer divide functional unit. It is the inverse counterpart of the Wallace multiplier path. It accepts one signed or unsigned 32-bit divide from the reservation-station issue logic and returns the quotient and remainder, tagged, on a valid/ready result port toward the common data bus arbiter. Its latency is fixed and it is not pipelined: only one operation is in flight at a time.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- TAG_W, 4, width of the reservation-station tag carried with each operation.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; aborts any operation in flight (mispredict squash).
- in_valid  input  1  issue request.
- in_ready  output  1  high only in IDLE.
- in_tag  input  TAG_W  tag of the issuing reservation station.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  CDB grant.
- out_tag  output  TAG_W  tag of the result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  set when divisor was 0.

## Operation
- FSM states: IDLE, ITER, FIX, DONE.
- **IDLE**
  - On in_valid && in_ready, latch in_tag, is_signed, the operand signs, and the magnitudes of both operands.
  - For signed operands, magnitude is the two's-complement absolute value. The unsigned value 0x80000000 is valid.
  - Clear the 33-bit partial remainder, load iteration count 31, go to ITER.
- **ITER** (one quotient bit per cycle, 32 cycles)
  - Shift {partial remainder, quotient} left by 1.
  - If the partial remainder sign bit is 0, subtract the divisor magnitude; otherwise add it.
  - Quotient LSB = inverted sign of the new partial remainder.
  - Decrement the count. At count 0, go to FIX.
- **FIX** (one cycle)
  - If the partial remainder is negative, add the divisor magnitude back.
  - Negate the quotient when the operand signs differ (signed only).
  - Negate the remainder when the dividend was negative (signed only).
  - Register the results, go to DONE.
- **Divide by zero**
  - Not short-circuited: full latency still applies.
  - FIX forces quotient = 0xFFFFFFFF, remainder = original dividend, div_by_zero = 1.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF)
  - quotient = 0x80000000, remainder = 0, div_by_zero = 0.
  - This falls out of the magnitude datapath; no special case is needed.
- **DONE**
  - out_valid = 1 and the result is held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - A new operation cannot be accepted in the same cycle as the result handoff.
- **flush**
  - From any state, go to IDLE on the next edge; out_valid drops.
  - The in-flight result is discarded.
  - flush has priority over in_valid and out_ready in the same cycle.

## Timing
- **Reset values:** state = IDLE, in_ready = 1, out_valid = 0, out_tag = 0, quotient = 0, remainder = 0, div_by_zero = 0.
- **Reset mid-operation:** the block returns to these values immediately, with no pending result.
- **Latency:**
  - The accept edge is E0.
  - ITER occupies edges E1..E32.
  - FIX registers the result at E33.
  - out_valid is high in the cycle after E33 (33-cycle latency), independent of operand values.
- **Throughput:** one operation per 35 cycles minimum (accept, 33 cycles of work, one DONE cycle with out_ready already high, return to IDLE).
- **Output stability:** out_tag, quotient, remainder and div_by_zero change only at the FIX edge or on reset. They must not change while out_valid is high.
- **in_ready** is a pure function of state (== IDLE). It does not depend on in_valid.

## Structure
- **Shared package** (in the divider/multiplier common package):
  - state enum {IDLE, ITER, FIX, DONE};
  - DIV_WIDTH = 32;
  - DIV_ITERS = 32;
  - TAG_W default.
- **Sub-module div_addsub33:**
  - 33-bit add/subtract controlled by a sub input: b is XORed with sub, carry-in = sub.
  - Built on the team's parallel-prefix carry network, so the ITER critical path is one prefix adder.
  - Instantiated once, shared by ITER and the FIX restore step.
- **Sign negation:** separate incrementer, not shared with the iteration adder.

## Test plan
- **Unsigned divide:** dividend 100, divisor 7, is_signed 0 -> quotient 14, remainder 2, out_valid exactly 33 cycles after accept, out_tag echoed.
- **Signed divide:** dividend −7 (0xFFFFFFF9), divisor 2, is_signed 1 -> quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1).
- **Overflow and divide by zero:**
  - 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0, div_by_zero 0.
  - 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1.
- **Backpressure:** hold out_ready low for 10 cycles after out_valid -> outputs stable and in_ready low throughout; the handoff cycle returns the FSM to IDLE, and in_ready is high the following cycle.
- **flush:**
  - Assert flush at ITER cycle 15 -> IDLE next cycle, no out_valid.
  - Then 0xFFFFFFFF / 1 unsigned -> quotient 0xFFFFFFFF, remainder 0.
- **Async reset:** reset mid-ITER between clock edges -> in_ready 1 and out_valid 0 immediately; a subsequent 10 / 3 produces 3 remainder 1.
